fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the memory.
- Captures the combinational read data in the same cycle and buffers {pc, instruction, fault} in a small FIFO toward decode, using a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing and refetching, and stops on out-of-range fetch addresses.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally and
// queues {pc, instr, fault} toward decode through a small valid/ready FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_0FFF,
  parameter int          DEPTH      = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  input  logic        instr_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  entry_t        fifo_q [DEPTH];
  entry_t        head;
  logic          fault_pc, push, pop;

  assign fault_pc = (pc_q > IMEM_LIMIT) || (pc_q[1:0] != 2'b00);
  assign pop      = (count_q != '0) && instr_ready_i;
  // A full FIFO still accepts a fetch when the head leaves on the same edge.
  assign push     = (state_q == RUN) && !redirect_i && ((count_q < DEPTH_C) || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (push && fault_pc) state_d = STOP;
      STOP:    state_d = STOP;
      default: state_d = IDLE;
    endcase
    if (redirect_i) state_d = RUN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        // Flush wins over everything, including a pop offered this cycle.
        pc_q     <= redirect_pc_i;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          pc_q     <= pc_q + 32'd4;
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload storage needs no reset; it is only observed through count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q].pc    <= pc_q;
      fifo_q[wr_ptr_q].instr <= fault_pc ? 32'd0 : imem_rdata_i;
      fifo_q[wr_ptr_q].fault <= fault_pc;
    end
  end

  assign head          = fifo_q[rd_ptr_q];
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? head.instr : 32'd0;
  assign instr_pc_o    = instr_valid_o ? head.pc    : 32'd0;
  assign instr_fault_o = instr_valid_o & head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with fixed expectations plus a randomized
// run compared against a queue-based reference model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0000_0FFF;
  localparam int          DEPTH      = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o, instr_fault_o, instr_ready_i;
  logic [31:0] instr_o, instr_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_LIMIT(IMEM_LIMIT), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_fault_o(instr_fault_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  // Reference model: a queue of expected entries, the fetch pointer and a mode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  int          mmode;  // 0 waiting one cycle after reset, 1 fetching, 2 halted on fault

  task automatic model_reset();
    mq.delete();
    mpc   = RESET_PC;
    mmode = 0;
  endtask

  task automatic model_step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit   pop, push, f;
    ent_t e;
    if (redir) begin
      mq.delete();
      mpc   = rpc;
      mmode = 1;
      return;
    end
    pop  = (mq.size() > 0) && rdy;
    push = (mmode == 1) && ((mq.size() < DEPTH) || pop);
    if (pop) mq.delete(0);
    if (push) begin
      f       = (mpc > IMEM_LIMIT) || (mpc[1:0] != 2'b00);
      e.pc    = mpc;
      e.instr = f ? 32'd0 : mem_word(mpc);
      e.fault = f;
      mq.push_back(e);
      mpc = mpc + 32'd4;
      if (f) mmode = 2;
    end
    if (mmode == 0) mmode = 1;
  endtask

  // Called at a falling edge; applies inputs across one rising edge, returns at the next falling edge.
  task automatic drive(input bit redir, input logic [31:0] rpc, input bit rdy);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    model_step(redir, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    instr_ready_i = 1'b1;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({instr_valid_o, instr_o, instr_pc_o, instr_fault_o, imem_addr_o} !== {1'b0, 32'd0, 32'd0, 1'b0, RESET_PC}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b i=%h pc=%h f=%0b a=%h want 0/0/0/0/%h",
               instr_valid_o, instr_o, instr_pc_o, instr_fault_o, imem_addr_o, RESET_PC);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    drive(0, 0, 1);
    n_tests++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_cycle: got valid=%0b want 0", instr_valid_o);
    end
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 1);
      n_tests++;
      if ({instr_valid_o, instr_pc_o, instr_o, instr_fault_o} !== {1'b1, 32'(4*k), 32'h1000_0000 + 32'(k), 1'b0}) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%0b pc=%h i=%h f=%0b want 1/%h/%h/0",
                 k, instr_valid_o, instr_pc_o, instr_o, instr_fault_o, 32'(4*k), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0);
      if (i >= 1) begin
        n_tests++;
        if ({instr_valid_o, instr_pc_o, imem_addr_o} !== {1'b1, 32'h0, 32'h8}) begin
          n_fail++;
          $display("FAIL bp_hold_%0d: got v=%0b pc=%h addr=%h want 1/0/8", i, instr_valid_o, instr_pc_o, imem_addr_o);
        end
      end
    end
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_pc_o} !== {1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL bp_release_1: got v=%0b pc=%h want 1/4", instr_valid_o, instr_pc_o);
    end
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h8, 32'h1000_0002}) begin
      n_fail++;
      $display("FAIL bp_release_2: got v=%0b pc=%h i=%h want 1/8/10000002", instr_valid_o, instr_pc_o, instr_o);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    drive(0, 0, 1);
    repeat (3) drive(0, 0, 0);
    drive(1, 32'h100, 1);
    n_tests++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_flush: got valid=%0b want 0", instr_valid_o);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1);
      n_tests++;
      if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h100 + 32'(4*k), 32'h1000_0040 + 32'(k)}) begin
        n_fail++;
        $display("FAIL redir_stream_%0d: got v=%0b pc=%h i=%h want 1/%h/%h", k, instr_valid_o,
                 instr_pc_o, instr_o, 32'h100 + 32'(4*k), 32'h1000_0040 + 32'(k));
      end
    end
  endtask

  task automatic test_limit();
    do_reset();
    drive(0, 0, 1);
    drive(1, 32'hFF8, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_pc_o, instr_o, instr_fault_o} !== {1'b1, 32'hFFC, 32'h1000_03FF, 1'b0}) begin
      n_fail++;
      $display("FAIL limit_last_ok: got v=%0b pc=%h i=%h f=%0b want 1/ffc/100003ff/0",
               instr_valid_o, instr_pc_o, instr_o, instr_fault_o);
    end
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_pc_o, instr_o, instr_fault_o, imem_addr_o} !== {1'b1, 32'h1000, 32'h0, 1'b1, 32'h1004}) begin
      n_fail++;
      $display("FAIL limit_fault: got v=%0b pc=%h i=%h f=%0b a=%h want 1/1000/0/1/1004",
               instr_valid_o, instr_pc_o, instr_o, instr_fault_o, imem_addr_o);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1);
      n_tests++;
      if ({instr_valid_o, imem_addr_o} !== {1'b0, 32'h1004}) begin
        n_fail++;
        $display("FAIL limit_stop_%0d: got v=%0b a=%h want 0/1004", i, instr_valid_o, imem_addr_o);
      end
    end
    drive(1, 32'h0, 1);
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_pc_o, instr_o, instr_fault_o} !== {1'b1, 32'h0, 32'h1000_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL limit_restart: got v=%0b pc=%h i=%h f=%0b want 1/0/10000000/0",
               instr_valid_o, instr_pc_o, instr_o, instr_fault_o);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive(0, 0, 1);
    drive(1, 32'h202, 1);
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_pc_o, instr_o, instr_fault_o} !== {1'b1, 32'h202, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL misalign_fault: got v=%0b pc=%h i=%h f=%0b want 1/202/0/1",
               instr_valid_o, instr_pc_o, instr_o, instr_fault_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1);
      n_tests++;
      if ({instr_valid_o, imem_addr_o} !== {1'b0, 32'h206}) begin
        n_fail++;
        $display("FAIL misalign_stop_%0d: got v=%0b a=%h want 0/206", i, instr_valid_o, imem_addr_o);
      end
    end
    // Top-of-space fetch faults and the pc wraps to zero.
    drive(1, 32'hFFFF_FFFC, 1);
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_fault_o, imem_addr_o} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_fault: got v=%0b f=%0b a=%h want 1/1/0", instr_valid_o, instr_fault_o, imem_addr_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 1);
    repeat (3) drive(0, 0, 0);
    n_tests++;
    if ({instr_valid_o, imem_addr_o} !== {1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%0b a=%h want 1/8", instr_valid_o, imem_addr_o);
    end
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({instr_valid_o, instr_pc_o, imem_addr_o} !== {1'b0, 32'h0, RESET_PC}) begin
      n_fail++;
      $display("FAIL areset_async: got v=%0b pc=%h a=%h want 0/0/%h", instr_valid_o, instr_pc_o, imem_addr_o, RESET_PC);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    drive(0, 0, 1);
    n_tests++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: got valid=%0b want 0", instr_valid_o);
    end
    drive(0, 0, 1);
    n_tests++;
    if ({instr_valid_o, instr_pc_o} !== {1'b1, RESET_PC}) begin
      n_fail++;
      $display("FAIL areset_restart: got v=%0b pc=%h want 1/%h", instr_valid_o, instr_pc_o, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          redir, rdy;
    logic [31:0] rpc;
    logic        ev, ef;
    logic [31:0] ei, ep;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ev = mq.size() > 0;
      ei = ev ? mq[0].instr : 32'd0;
      ep = ev ? mq[0].pc : 32'd0;
      ef = ev ? mq[0].fault : 1'b0;
      n_tests++;
      if ({instr_valid_o, instr_o, instr_pc_o, instr_fault_o, imem_addr_o} !== {ev, ei, ep, ef, mpc}) begin
        n_fail++;
        $display("FAIL random_c%0d: got v=%0b i=%h pc=%h f=%0b a=%h want %0b/%h/%h/%0b/%h",
                 c, instr_valid_o, instr_o, instr_pc_o, instr_fault_o, imem_addr_o, ev, ei, ep, ef, mpc);
      end
      redir = (mmode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2: rpc = 32'($urandom_range(0, 1023)) << 2;
        3:       rpc = 32'hFF0;
        4:       rpc = 32'($urandom_range(0, 4095)) | 32'h1;
        5:       rpc = 32'hFFFF_FFF8;
        6:       rpc = 32'h1000;
        default: rpc = 32'hFE0 + (32'($urandom_range(0, 7)) << 2);
      endcase
      rdy = ($urandom_range(0, 9) < 7);
      drive(redir, rpc, rdy);
    end
  endtask

  initial begin
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    instr_ready_i = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_backpressure();
    test_redirect_full();
    test_limit();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
